// File: rtl/peripheral_noc_inject_arbiter.sv
// peripheral_noc_inject_arbiter
// Packet-atomic round-robin arbiter sharing one NoC injection lane among
// REQUESTERS local sources. The winner keeps the lane from its first flit to
// its last flit; flits reach the lane through one registered output stage.
// Optional feature: define PERIPHERAL_NOC_ARB_MAXLEN_EN to cut packets at
// MAX_FLITS flits (forced out_last, err_maxlen pulse, remainder sunk).
`timescale 1ns/1ps
module peripheral_noc_inject_arbiter #(
  parameter int FLIT_WIDTH = 34,
  parameter int REQUESTERS = 4,
  parameter int MAX_FLITS  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQUESTERS*FLIT_WIDTH-1:0] in_flit,
  input  logic [REQUESTERS-1:0]            in_last,
  input  logic [REQUESTERS-1:0]            in_valid,
  output logic [REQUESTERS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]            out_flit,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [REQUESTERS-1:0]            grant,
  output logic                             err_maxlen
);

  localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  if (REQUESTERS < 2) begin : g_chk_requesters
    $error("peripheral_noc_inject_arbiter: REQUESTERS must be >= 2");
  end
  if (MAX_FLITS < 2) begin : g_chk_max_flits
    $error("peripheral_noc_inject_arbiter: MAX_FLITS must be >= 2");
  end

`ifdef PERIPHERAL_NOC_ARB_MAXLEN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DROP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} state_t;
`endif

  state_t                state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      owner_idx;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      next_ptr;
  logic                  pick_found;
  logic                  stage_free;
  logic                  accept;
  logic                  emit;
  logic                  trunc;
  logic                  owner_last;
  logic [FLIT_WIDTH-1:0] owner_flit;
  int                    cand;

  // The output register can take a new flit when empty or being drained.
  assign stage_free = !out_valid || out_ready;

  assign owner_last = in_last[owner_idx];
  assign owner_flit = in_flit[int'(owner_idx)*FLIT_WIDTH +: FLIT_WIDTH];

  // Pointer to the source after the current owner, wrapping at REQUESTERS-1.
  assign next_ptr = (owner_idx == IDX_W'(REQUESTERS - 1)) ? '0 : owner_idx + 1'b1;

  // Round-robin search: first valid source at or above rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < REQUESTERS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= REQUESTERS) cand = cand - REQUESTERS;
      if (!pick_found && in_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // Only the owner sees ready; while sinking a cut packet it ignores the stage.
  always_comb begin
    in_ready = '0;
    case (state)
      BUSY:    in_ready = grant & {REQUESTERS{stage_free}};
`ifdef PERIPHERAL_NOC_ARB_MAXLEN_EN
      DROP:    in_ready = grant;
`endif
      default: in_ready = '0;
    endcase
  end

  assign accept = |(in_ready & in_valid);
  assign emit   = accept && (state == BUSY);

`ifdef PERIPHERAL_NOC_ARB_MAXLEN_EN
  localparam int CNT_W = $clog2(MAX_FLITS);
  logic [CNT_W-1:0] flit_cnt;

  // The MAX_FLITS-th flit without last ends the packet on the lane.
  assign trunc = emit && !owner_last && (flit_cnt == CNT_W'(MAX_FLITS - 1));
`else
  assign trunc      = 1'b0;
  assign err_maxlen = 1'b0;
`endif

  // Ownership FSM: arbitrate in IDLE, hold the winner until its last flit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      owner_idx <= '0;
`ifdef PERIPHERAL_NOC_ARB_MAXLEN_EN
      flit_cnt   <= '0;
      err_maxlen <= 1'b0;
`endif
    end else begin
`ifdef PERIPHERAL_NOC_ARB_MAXLEN_EN
      err_maxlen <= trunc;
`endif
      case (state)
        IDLE: begin
`ifdef PERIPHERAL_NOC_ARB_MAXLEN_EN
          flit_cnt <= '0;
`endif
          if (pick_found) begin
            grant     <= {{(REQUESTERS-1){1'b0}}, 1'b1} << pick_idx;
            owner_idx <= pick_idx;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            if (owner_last) begin
              state  <= IDLE;
              grant  <= '0;
              rr_ptr <= next_ptr;
`ifdef PERIPHERAL_NOC_ARB_MAXLEN_EN
              flit_cnt <= '0;
            end else if (trunc) begin
              state    <= DROP;
              flit_cnt <= '0;
            end else begin
              flit_cnt <= flit_cnt + 1'b1;
`endif
            end
          end
        end
`ifdef PERIPHERAL_NOC_ARB_MAXLEN_EN
        DROP: begin
          if (accept && owner_last) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= next_ptr;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: load an emitted flit, release valid once the lane took it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_flit  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (emit) begin
      out_flit  <= owner_flit;
      out_last  <= owner_last || trunc;
      out_valid <= 1'b1;
    end else if (stage_free) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_peripheral_noc_inject_arbiter.sv
// Testbench for peripheral_noc_inject_arbiter: directed scenarios plus a
// randomized phase, all checked against a behavioural reference model.
`timescale 1ns/1ps
module tb_peripheral_noc_inject_arbiter;

  localparam int FW = 34;
  localparam int NR = 4;
  localparam int MF = 4;
`ifdef PERIPHERAL_NOC_ARB_MAXLEN_EN
  localparam bit MAXLEN = 1'b1;
`else
  localparam bit MAXLEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR*FW-1:0] in_flit = '0;
  logic [NR-1:0]    in_last = '0;
  logic [NR-1:0]    in_valid = '0;
  logic [NR-1:0]    in_ready;
  logic [FW-1:0]    out_flit;
  logic             out_last;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [NR-1:0]    grant;
  logic             err_maxlen;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  peripheral_noc_inject_arbiter #(
    .FLIT_WIDTH(FW),
    .REQUESTERS(NR),
    .MAX_FLITS (MF)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .err_maxlen(err_maxlen)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Source side: per-source packet queues replayed onto in_* lanes.
  typedef struct packed {
    logic [FW-1:0] d;
    logic          last;
  } flit_t;

  flit_t src_q[NR][$];
  int    hold[NR];
  bit    acc_seen[NR];
  int    gap_pct = 0;
  int    or_mode = 0;

  task automatic push_pkt(input int s, input int len, input logic [FW-1:0] base);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.d    = base + FW'(k);
      f.last = (k == len - 1);
      src_q[s].push_back(f);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++)
      if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : src_driver
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (hold[i] > 0) begin
        in_valid[i] = 1'b0;
        hold[i]     = hold[i] - 1;
      end else if (src_q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
        in_valid[i]            = 1'b1;
        in_flit[i*FW +: FW]    = src_q[i][0].d;
        in_last[i]             = src_q[i][0].last;
      end else begin
        in_valid[i] = 1'b0;
      end
    end
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(99) < 75);
      default: out_ready = 1'b0;
    endcase
  end

  // Reference model: owner, round-robin pointer and the one-entry output
  // stage, stepped once per cycle from the arbitration rules.
  bit            m_busy = 0, m_drop = 0, m_ov = 0, m_ol = 0, m_err = 0;
  int            m_owner = 0, m_ptr = 0, m_cnt = 0;
  logic [FW-1:0] m_of = '0;

  always @(negedge clk) begin : ref_model
    logic [NR-1:0] own, exp_rdy;
    bit            sf, acc, emit, lst, trunc;
    int            j;
    if (!rst) begin
      m_busy = 0; m_drop = 0; m_ov = 0; m_ol = 0; m_err = 0;
      m_owner = 0; m_ptr = 0; m_cnt = 0;
      for (int i = 0; i < NR; i++) acc_seen[i] = 1'b0;
      check("rst_grant", grant, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_flit", out_flit, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_err", err_maxlen, 0);
    end else begin
      own = m_busy ? (NR'(1) << m_owner) : '0;
      check("grant", grant, own);
      check("out_valid", out_valid, m_ov);
      if (m_ov) begin
        check("out_flit", out_flit, m_of);
        check("out_last", out_last, m_ol);
      end
      check("err_maxlen", err_maxlen, m_err);
      sf      = !m_ov || out_ready;
      exp_rdy = (m_drop || sf) ? own : '0;
      check("in_ready", in_ready, exp_rdy);
      for (int i = 0; i < NR; i++) acc_seen[i] = in_valid[i] && in_ready[i];

      acc   = m_busy && in_valid[m_owner] && (m_drop || sf);
      lst   = in_last[m_owner];
      emit  = acc && !m_drop;
      trunc = 0;
      m_err = 0;
      if (emit) begin
        m_cnt++;
        trunc = MAXLEN && (m_cnt == MF) && !lst;
        m_of  = in_flit[m_owner*FW +: FW];
        m_ol  = lst || trunc;
        m_ov  = 1;
      end else if (sf) begin
        m_ov = 0;
      end
      if (acc) begin
        if (lst) begin
          m_busy = 0;
          m_drop = 0;
          m_ptr  = (m_owner + 1) % NR;
        end else if (trunc) begin
          m_drop = 1;
          m_err  = 1;
        end
      end else if (!m_busy && in_valid != '0) begin
        for (int k = 0; k < NR; k++) begin
          j = (m_ptr + k) % NR;
          if (in_valid[j]) begin
            m_owner = j;
            break;
          end
        end
        m_busy = 1;
        m_cnt  = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_any(input string tag, input logic [NR-1:0] want, input int max_cyc);
    int c;
    c = 0;
    while (grant == '0 && c < max_cyc) begin
      cycles(1);
      c++;
    end
    check(tag, grant, want);
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int c;
    c = 0;
    while ((pending() || grant != '0 || out_valid) && c < max_cyc) begin
      cycles(1);
      c++;
    end
    check(tag, (c >= max_cyc), 0);
  endtask

  logic [63:0] sq_g[8], sq_v[8], sq_f[8], sq_l[8];

  task automatic run_seq(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      cycles(1);
      check({tag, "_grant"}, grant, sq_g[k]);
      check({tag, "_valid"}, out_valid, sq_v[k]);
      if (sq_v[k][0]) begin
        check({tag, "_flit"}, out_flit, sq_f[k]);
        check({tag, "_last"}, out_last, sq_l[k]);
      end
    end
  endtask

  task automatic count_window(input int n, output int n_out, output int n_last, output int n_err);
    n_out = 0; n_last = 0; n_err = 0;
    for (int k = 0; k < n; k++) begin
      cycles(1);
      if (out_valid) n_out++;
      if (out_valid && out_last) n_last++;
      if (err_maxlen) n_err++;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [FW-1:0] snap;
    logic [FW-1:0] b;
    int            c, seq, n_out, n_last, n_err;
    for (int i = 0; i < NR; i++) hold[i] = 0;
    seq = 0;

    rst = 1'b0;
    cycles(3);
    rst = 1'b1;

    // T1: single source, three flits, exact latency
    push_pkt(1, 3, 'hA1);
    sq_g = '{0, 2, 2, 2, 0, 0, 0, 0};
    sq_v = '{0, 0, 1, 1, 1, 0, 0, 0};
    sq_f = '{0, 0, 'hA1, 'hA2, 'hA3, 0, 0, 0};
    sq_l = '{0, 0, 0, 0, 1, 0, 0, 0};
    run_seq("t1", 6);

    // T2: src0 and src2 pending together after reset, one idle cycle between
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    push_pkt(0, 2, 'hB0);
    push_pkt(2, 2, 'hC0);
    sq_g = '{0, 1, 1, 0, 4, 4, 0, 0};
    sq_v = '{0, 0, 1, 1, 0, 1, 1, 0};
    sq_f = '{0, 0, 'hB0, 'hB1, 0, 'hC0, 'hC1, 0};
    sq_l = '{0, 0, 0, 1, 0, 0, 1, 0};
    run_seq("t2", 8);
    push_pkt(1, 1, 'hD0);
    push_pkt(3, 1, 'hE0);
    wait_any("t2_search_from_3", 4'b1000, 20);
    drain("t2_drain", 100);

    // T3: lane back-pressure mid-packet
    push_pkt(0, 6, 'h300);
    c = 0;
    while (!out_valid && c < 20) begin
      cycles(1);
      c++;
    end
    check("t3_started", out_valid, 1);
    cycles(1);
    or_mode = 2;
    snap = '0;
    for (int k = 0; k < 5; k++) begin
      cycles(1);
      if (k == 0) snap = out_flit;
      else check("t3_hold_flit", out_flit, snap);
      check("t3_hold_valid", out_valid, 1);
      check("t3_in_ready", in_ready, 0);
    end
    or_mode = 0;
    drain("t3_drain", 100);

    // T4: owner pauses mid-packet while src3 waits
    push_pkt(1, 5, 'h400);
    wait_any("t4_grant", 4'b0010, 20);
    cycles(1);
    hold[1] = 3;
    push_pkt(3, 2, 'h480);
    for (int k = 0; k < 5; k++) begin
      cycles(1);
      check("t4_grant_held", grant, 4'b0010);
      check("t4_src3_ready", in_ready[3], 0);
    end
    drain("t4_drain", 100);

    // T5: reset mid-packet, then arbitration restarts from pointer 0
    push_pkt(1, 1, 'h500);
    push_pkt(2, 8, 'h510);
    wait_any("t5_first", 4'b0010, 20);
    cycles(2);
    wait_any("t5_second", 4'b0100, 20);
    cycles(2);
    rst = 1'b0;
    #1;
    check("t5_grant", grant, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_out_last", out_last, 0);
    check("t5_out_flit", out_flit, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_err", err_maxlen, 0);
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      hold[i] = 0;
    end
    cycles(2);
    rst = 1'b1;
    push_pkt(1, 2, 'h5A0);
    push_pkt(3, 2, 'h5B0);
    wait_any("t5_fresh_arb", 4'b0010, 20);
    drain("t5_drain", 100);

`ifdef PERIPHERAL_NOC_ARB_MAXLEN_EN
    // T6: over-length packet is cut at MF flits, exact-length packet is not
    push_pkt(0, 6, 'h600);
    count_window(20, n_out, n_last, n_err);
    check("t6_long_flits", n_out, MF);
    check("t6_long_last", n_last, 1);
    check("t6_long_err", n_err, 1);
    check("t6_long_sunk", src_q[0].size(), 0);
    push_pkt(0, MF, 'h700);
    count_window(20, n_out, n_last, n_err);
    check("t6_exact_flits", n_out, MF);
    check("t6_exact_last", n_last, 1);
    check("t6_exact_err", n_err, 0);
`else
    // Without length limiting a long packet passes whole with no error
    push_pkt(0, 10, 'h600);
    count_window(25, n_out, n_last, n_err);
    check("long_flits", n_out, 10);
    check("long_last", n_last, 1);
    check("long_err", n_err, 0);
`endif

    // Randomized traffic with gaps and lane back-pressure
    gap_pct = 20;
    or_mode = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      cycles(1);
      for (int s = 0; s < NR; s++) begin
        if (src_q[s].size() < 8 && $urandom_range(7) == 0) begin
          seq++;
          b = FW'((seq << 8) + (s << 4));
          push_pkt(s, 1 + int'($urandom_range(MAXLEN ? 5 : 7)), b);
        end
      end
    end
    gap_pct = 0;
    or_mode = 0;
    drain("rand_drain", 2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
